// File: rtl/led_seq_ctrl.sv
// Command sequencer for the button/LED datapath.
// Arbitrates one-cycle button ticks by fixed priority (clear > pause > up > down)
// and steps a 4-bit up/down count once every DIV cycles while running.
module led_seq_ctrl #(
  parameter int unsigned DIV  = 50_000_000,
  parameter bit          WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_tick,
  output logic [3:0] leds,
  output logic [1:0] state,
  output logic       step
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(DIV - 1);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StUp    = 2'b01;
  localparam logic [1:0] StDown  = 2'b10;
  localparam logic [1:0] StPause = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [3:0]    leds_q, leds_d;
  logic          step_q, step_d;
  logic          dir_dn_q, dir_dn_d;
  logic [PW-1:0] pre_q, pre_d;

  logic cmd_clr, cmd_pause, cmd_up, cmd_down;
  logic running, at_end;

  // Fixed-priority decode; lower-priority bits in the same cycle are dropped.
  always_comb begin
    cmd_clr   = btn_tick[3];
    cmd_pause = !btn_tick[3] && btn_tick[2];
    cmd_up    = !btn_tick[3] && !btn_tick[2] && btn_tick[0];
    cmd_down  = !btn_tick[3] && !btn_tick[2] && !btn_tick[0] && btn_tick[1];
    running   = (state_q == StUp) || (state_q == StDown);
    at_end    = ((state_q == StUp) && (leds_q == 4'hF)) ||
                ((state_q == StDown) && (leds_q == 4'h0));
  end

  // Next-state: accepted commands win over a coincident step boundary.
  always_comb begin
    state_d  = state_q;
    leds_d   = leds_q;
    dir_dn_d = dir_dn_q;
    pre_d    = pre_q;
    step_d   = 1'b0;
    if (cmd_clr) begin
      state_d  = StIdle;
      leds_d   = 4'h0;
      dir_dn_d = 1'b0;
      pre_d    = '0;
    end else if (cmd_pause) begin
      // Pause in IDLE is ignored entirely.
      if (running) begin
        state_d = StPause;
        pre_d   = '0;
      end else if (state_q == StPause) begin
        state_d = dir_dn_q ? StDown : StUp;
        pre_d   = '0;
      end
    end else if (cmd_up) begin
      state_d  = StUp;
      dir_dn_d = 1'b0;
      pre_d    = '0;
    end else if (cmd_down) begin
      state_d  = StDown;
      dir_dn_d = 1'b1;
      pre_d    = '0;
    end else if (running) begin
      if (pre_q == PreMax) begin
        pre_d = '0;
        if (!WRAP && at_end) begin
          state_d = StIdle;
        end else begin
          leds_d = (state_q == StDown) ? leds_q - 4'd1 : leds_q + 4'd1;
          step_d = 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      leds_q   <= 4'h0;
      step_q   <= 1'b0;
      dir_dn_q <= 1'b0;
      pre_q    <= '0;
    end else begin
      state_q  <= state_d;
      leds_q   <= leds_d;
      step_q   <= step_d;
      dir_dn_q <= dir_dn_d;
      pre_q    <= pre_d;
    end
  end

  assign leds  = leds_q;
  assign state = state_q;
  assign step  = step_q;

endmodule
